id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. It latches the fetched instruction and PC+4 into an IF/ID register, reads the 32x32 register file, and decodes control. It resolves beq/bne/j in decode and returns the redirect (`pc_branch`, `branch`) to fetch. It detects load-use and ALU-to-branch hazards, and drives a registered ID/EX bundle to execute.

## Interface
- `W`, default `` `N+1`` (32): datapath width, taken from define.v.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-low reset.
- `PcPlus4_F` in W: PC+4 from fetch.
- `Instruction_F` in W: fetched instruction.
- `ex_reg_write` in 1: instruction currently in EX writes a register.
- `ex_mem_read` in 1: instruction currently in EX is lw.
- `ex_dst` in 5: destination register of the EX instruction.
- `wb_we` in 1: write-back enable.
- `wb_addr` in 5: write-back register.
- `wb_data` in W: write-back data.
- `stall_F` out 1: fetch must hold PC and IF/ID this cycle; combinational.
- `branch` out 1: taken redirect; combinational.
- `pc_branch` out W: redirect target; combinational.
- `valid_E` out 1: ID/EX slot holds a real instruction.
- `PcPlus4_E`, `rs_data_E`, `rt_data_E`, `imm_E` out W each: registered operands; `imm_E` is sign-extended.
- `rs_E`, `rt_E`, `rd_E` out 5 each: registered register numbers.
- `ctrl_E` out 10: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0]}.

## Operation
- **Supported instructions:** R-type add/sub/and/or/slt, lw, sw, addi, beq, bne, j.
- **Unknown opcode or funct:** decodes to all-zero ctrl, i.e. a NOP with `valid_E`=1.
- **IF/ID register:** {valid_D, instr_D, pc4_D}. Each cycle it loads {1, `Instruction_F`, `PcPlus4_F`}, except:
  - stall: hold;
  - branch and not stall: load bubble {0, 0, 0}, squashing the wrong-path fetch.
- **Register file:** two combinational reads, one synchronous write.
  - $0 always reads 0; writes to it are ignored.
  - WB bypass: if `wb_we` && `wb_addr`==src && src!=0, the read returns `wb_data`.
- **Hazard stall:** stall = valid_D && `ex_dst`!=0 && (`ex_dst`==rs_used || `ex_dst`==rt_used) && (`ex_mem_read` || (is_beq_bne && `ex_reg_write`)).
  - rt_used is true only for R-type, sw, beq and bne.
- **Branch resolution:** requires valid_D and !stall.
  - beq taken when rs==rt; bne taken when rs!=rt. Target = pc4_D + (sext(imm16)<<2), mod 2^32.
  - j is always taken. Target = {pc4_D[31:28], instr[25:0], 2'b00}.
- **MEM-stage producers:** not forwarded to branch operands. The toolchain schedules around this.
- **ID/EX register:**
  - Loads the decoded bundle with `valid_E`=valid_D.
  - On stall, or when valid_D=0, it loads a bubble: `valid_E`=0, ctrl_E=0, other fields 0.
  - Taken branches and j still pass to EX as ctrl_E=0 with `valid_E`=1.

## Timing
- **Reset** (`rst`=0 at a rising edge): IF/ID becomes a bubble, all 32 registers are cleared, and every ID/EX output is 0. Consequently `stall_F`=0, `branch`=0 and `pc_branch`=0 on the following cycle.
- **Reset mid-stall:** reset wins.
- **Latency:** an instruction presented on `Instruction_F` at edge k is in decode during cycle k+1 and appears on the `_E` outputs after edge k+2.
- **Stall duration:** one cycle per load-use or ALU-to-branch dependency. `stall_F` and the IF/ID hold take effect on the same edge.
- **Stall and branch together:** stall wins and `branch` is forced to 0. The branch resolves the cycle after the stall clears.
- **Register write then read in the same cycle:** the read returns the new value.
- **Branch penalty:** one squashed fetch.

## Structure
- **define.v:** owns `` `N``, the opcode and funct localparams, the alu_op encodings, and the ctrl_E bit positions.
- **Sub-module `reg_file`:** 32xW storage with two read ports, one write port, $0 hardwired to 0, and the WB bypass.
- **Everything else** (decode, hazard logic, branch compare, pipeline registers) lives in `id_stage`.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles, then release. Required: all `_E` outputs 0, `branch`=0, `stall_F`=0, and a read of r5 returns 0.
- **Register write/read bypass:** WB writes r3=0x1234 while decode holds `add r1,r3,r3`. Required: next cycle `rs_data_E`=`rt_data_E`=0x1234, ctrl_E.reg_write=1, `rd_E`=1.
- **Load-use:** EX holds lw to r4 (`ex_mem_read`=1, `ex_dst`=4); decode holds `add r2,r4,r0`. Required: `stall_F`=1 for exactly one cycle, the ID/EX bubble has `valid_E`=0, and the add issues on the following cycle.
- **beq taken:** r1=r2=7, pc4_D=0x100, imm=0x0003. Required: `branch`=1, `pc_branch`=0x10C, and the next IF/ID holds a bubble.
- **bne negative offset:** imm=0xFFFE, pc4_D=0x100, r1!=r2. Required: `pc_branch`=0xF8.
- **j:** pc4_D=0x40000004, target field 0x10. Required: `pc_branch`=0x40000040.
- **Stall and branch together:** beq reads r4 while EX lw writes r4. Required: `branch`=0 during the stall, then the branch resolves correctly on the next cycle.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared constants for the decode stage: datapath width, MIPS opcode/funct
// values, ALU operation codes and the ID/EX control bundle layout.
package id_stage_pkg;

   localparam int N      = 31;
   localparam int DATA_W = N + 1;

   // primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation encodings carried in ctrl_E[3:0]
   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;

   // ctrl_E bit positions
   localparam int CTRL_REG_WRITE  = 9;
   localparam int CTRL_MEM_READ   = 8;
   localparam int CTRL_MEM_WRITE  = 7;
   localparam int CTRL_MEM_TO_REG = 6;
   localparam int CTRL_ALU_SRC    = 5;
   localparam int CTRL_REG_DST    = 4;

   // packed in the same order as the bit positions above
   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       reg_dst;
      logic [3:0] alu_op;
   } ctrl_t;

   // Control bundle for one instruction; anything unrecognised is a NOP.
   // Branches and jumps need no EX/MEM/WB action, so they also return zero.
   function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            case (fn)
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_OR:   c.alu_op = ALU_OR;
               FN_SLT:  c.alu_op = ALU_SLT;
               default: c = '0;
            endcase
         end
         OP_LW: begin
            c.reg_write  = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.alu_src    = 1'b1;
            c.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
            c.alu_op    = ALU_ADD;
         end
         OP_ADDI: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.alu_op    = ALU_ADD;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of the fetch, EX-feedback, write-back and ID/EX signals around the
// decode stage. The stage itself connects through the slave modport.
interface id_stage_if #(
   parameter int W = id_stage_pkg::DATA_W
);
   // from fetch
   logic [W-1:0] PcPlus4_F;
   logic [W-1:0] Instruction_F;
   // from execute (hazard detection)
   logic         ex_reg_write;
   logic         ex_mem_read;
   logic [4:0]   ex_dst;
   // from write-back
   logic         wb_we;
   logic [4:0]   wb_addr;
   logic [W-1:0] wb_data;
   // back to fetch
   logic         stall_F;
   logic         branch;
   logic [W-1:0] pc_branch;
   // ID/EX register
   logic         valid_E;
   logic [W-1:0] PcPlus4_E;
   logic [W-1:0] rs_data_E;
   logic [W-1:0] rt_data_E;
   logic [W-1:0] imm_E;
   logic [4:0]   rs_E;
   logic [4:0]   rt_E;
   logic [4:0]   rd_E;
   logic [9:0]   ctrl_E;

   modport master (
      output PcPlus4_F, Instruction_F, ex_reg_write, ex_mem_read, ex_dst,
             wb_we, wb_addr, wb_data,
      input  stall_F, branch, pc_branch, valid_E, PcPlus4_E, rs_data_E,
             rt_data_E, imm_E, rs_E, rt_E, rd_E, ctrl_E
   );

   modport slave (
      input  PcPlus4_F, Instruction_F, ex_reg_write, ex_mem_read, ex_dst,
             wb_we, wb_addr, wb_data,
      output stall_F, branch, pc_branch, valid_E, PcPlus4_E, rs_data_E,
             rt_data_E, imm_E, rs_E, rt_E, rd_E, ctrl_E
   );
endinterface

// File: rtl/id_stage_reg_file.sv
// 32-entry register file: two combinational reads, one synchronous write,
// $0 hardwired to zero, and a write-back bypass so a same-cycle write is
// visible to decode without waiting for the edge.
module reg_file
   import id_stage_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [4:0]   ra1,
   input  logic [4:0]   ra2,
   output logic [W-1:0] rd1,
   output logic [W-1:0] rd2,
   input  logic         we,
   input  logic [4:0]   wa,
   input  logic [W-1:0] wd
);

   logic [W-1:0] mem [32];

   // storage: cleared on reset, writes to $0 dropped
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (we && wa != 5'd0) begin
         mem[wa] <= wd;
      end
   end

   // read ports with $0 forcing and write-back bypass
   always_comb begin
      rd1 = mem[ra1];
      rd2 = mem[ra2];
      if (we && wa == ra1) rd1 = wd;
      if (we && wa == ra2) rd2 = wd;
      if (ra1 == 5'd0) rd1 = '0;
      if (ra2 == 5'd0) rd2 = '0;
   end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, register-file read, control decode,
// load-use / ALU-to-branch stall, beq/bne/j resolution and the ID/EX register.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int W = DATA_W
) (
   input logic        clk,
   input logic        rst,
   id_stage_if.slave  bus
);

   // IF/ID register
   logic         valid_D;
   logic [W-1:0] instr_D;
   logic [W-1:0] pc4_D;

   // instruction fields
   logic [5:0]   op;
   logic [5:0]   funct;
   logic [4:0]   rs;
   logic [4:0]   rt;
   logic [4:0]   rd;
   logic [15:0]  imm16;

   logic [W-1:0] rs_val;
   logic [W-1:0] rt_val;
   logic [W-1:0] imm_ext;
   logic [W-1:0] br_tgt;
   logic [W-1:0] j_tgt;
   ctrl_t        ctrl;

   logic is_rtype, is_beq, is_bne, is_j;
   logic rs_used, rt_used;
   logic stall, taken, branch;

   assign op      = instr_D[31:26];
   assign rs      = instr_D[25:21];
   assign rt      = instr_D[20:16];
   assign rd      = instr_D[15:11];
   assign funct   = instr_D[5:0];
   assign imm16   = instr_D[15:0];
   assign imm_ext = {{(W-16){imm16[15]}}, imm16};

   reg_file #(.W(W)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (rs_val),
      .rd2 (rt_val),
      .we  (bus.wb_we),
      .wa  (bus.wb_addr),
      .wd  (bus.wb_data)
   );

   // instruction class and which source registers it actually reads
   always_comb begin
      ctrl     = decode_ctrl(op, funct);
      is_rtype = (op == OP_RTYPE);
      is_beq   = (op == OP_BEQ);
      is_bne   = (op == OP_BNE);
      is_j     = (op == OP_J);
      rs_used  = is_rtype || is_beq || is_bne ||
                 op == OP_LW || op == OP_SW || op == OP_ADDI;
      rt_used  = is_rtype || is_beq || is_bne || op == OP_SW;
   end

   // hazard detection and branch resolution; a stall suppresses the
   // redirect so the branch resolves again once its operands are ready
   always_comb begin
      stall = valid_D && bus.ex_dst != 5'd0 &&
              ((rs_used && bus.ex_dst == rs) || (rt_used && bus.ex_dst == rt)) &&
              (bus.ex_mem_read || ((is_beq || is_bne) && bus.ex_reg_write));
      taken  = is_j || (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
      branch = valid_D && !stall && taken;
      br_tgt = pc4_D + (imm_ext << 2);
      j_tgt  = {pc4_D[W-1:W-4], instr_D[25:0], 2'b00};
   end

   assign bus.stall_F   = stall;
   assign bus.branch    = branch;
   assign bus.pc_branch = is_j ? j_tgt : br_tgt;

   // IF/ID: hold on stall, squash the wrong-path fetch on a redirect
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_D <= 1'b0;
         instr_D <= '0;
         pc4_D   <= '0;
      end else if (stall) begin
         valid_D <= valid_D;
         instr_D <= instr_D;
         pc4_D   <= pc4_D;
      end else if (branch) begin
         valid_D <= 1'b0;
         instr_D <= '0;
         pc4_D   <= '0;
      end else begin
         valid_D <= 1'b1;
         instr_D <= bus.Instruction_F;
         pc4_D   <= bus.PcPlus4_F;
      end
   end

   // ID/EX: decoded bundle, or an all-zero bubble when stalling or empty
   always_ff @(posedge clk) begin
      if (!rst || stall || !valid_D) begin
         bus.valid_E   <= 1'b0;
         bus.PcPlus4_E <= '0;
         bus.rs_data_E <= '0;
         bus.rt_data_E <= '0;
         bus.imm_E     <= '0;
         bus.rs_E      <= '0;
         bus.rt_E      <= '0;
         bus.rd_E      <= '0;
         bus.ctrl_E    <= '0;
      end else begin
         bus.valid_E   <= 1'b1;
         bus.PcPlus4_E <= pc4_D;
         bus.rs_data_E <= rs_val;
         bus.rt_data_E <= rt_val;
         bus.imm_E     <= imm_ext;
         bus.rs_E      <= rs;
         bus.rt_E      <= rt;
         bus.rd_E      <= rd;
         bus.ctrl_E    <= ctrl;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver applies one cycle of inputs at a
// time, a reference model predicts the combinational redirect/stall outputs
// and the ID/EX contents, and two monitors pop and compare them.
module tb_id_stage;
   import id_stage_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_stage_if #(.W(32)) bus ();

   id_stage #(.W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_ADDI,
                 K_BEQ, K_BNE, K_J, K_RNOP, K_BAD} kind_t;

   typedef struct {
      logic        stall;
      logic        branch;
      logic [31:0] pc;
      bit          chk_pc;
   } comb_t;

   typedef struct {
      logic        v;
      logic [31:0] pc4, a, b, imm;
      logic [4:0]  rs, rt, rd;
      logic [9:0]  ctrl;
   } ex_t;

   comb_t comb_q[$];
   ex_t   ex_q[$];
   int    errs   = 0;
   int    checks = 0;

   // reference state: the instruction sitting in decode and the register file
   bit          m_known = 0;
   bit          m_v     = 0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc4   = '0;
   logic [31:0] m_rf [32];

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd_, rs_, rt_);
      return {6'h00, rs_, rt_, rd_, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op_, input logic [4:0] rt_, rs_,
                                         input logic [15:0] im);
      return {op_, rs_, rt_, im};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction

   function automatic kind_t kind_of(input logic [31:0] i);
      case (i[31:26])
         6'h00: case (i[5:0])
                   6'h20: return K_ADD;
                   6'h22: return K_SUB;
                   6'h24: return K_AND;
                   6'h25: return K_OR;
                   6'h2A: return K_SLT;
                   default: return K_RNOP;
                endcase
         6'h23: return K_LW;
         6'h2B: return K_SW;
         6'h08: return K_ADDI;
         6'h04: return K_BEQ;
         6'h05: return K_BNE;
         6'h02: return K_J;
         default: return K_BAD;
      endcase
   endfunction

   // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op}
   function automatic logic [9:0] ctrl_of(input kind_t k);
      case (k)
         K_ADD:  return {6'b100001, ALU_ADD};
         K_SUB:  return {6'b100001, ALU_SUB};
         K_AND:  return {6'b100001, ALU_AND};
         K_OR:   return {6'b100001, ALU_OR};
         K_SLT:  return {6'b100001, ALU_SLT};
         K_LW:   return {6'b110110, ALU_ADD};
         K_SW:   return {6'b001010, ALU_ADD};
         K_ADDI: return {6'b100010, ALU_ADD};
         default: return 10'd0;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      int          k  = $urandom_range(0, 12);
      logic [4:0]  r1 = 5'($urandom_range(0, 7));
      logic [4:0]  r2 = 5'($urandom_range(0, 7));
      logic [4:0]  r3 = 5'($urandom_range(0, 7));
      logic [15:0] im = 16'($urandom);
      case (k)
         0, 1, 2, 3, 4: return enc_r(fns[k], r1, r2, r3);
         5:  return enc_i(6'h23, r1, r2, im);
         6:  return enc_i(6'h2B, r1, r2, im);
         7:  return enc_i(6'h08, r1, r2, im);
         8:  return enc_i(6'h04, r1, r2, im);
         9:  return enc_i(6'h05, r1, r2, im);
         10: return enc_j(26'($urandom));
         11: return {6'h3F, 26'($urandom)};
         default: return enc_r(6'h00, r1, r2, r3);
      endcase
   endfunction

   // One clock of stimulus: drive inputs, predict, push, advance the model.
   task automatic step(input logic [31:0] instr, pc4, input bit exrw, exmr,
                       input logic [4:0] exdst, input bit wbwe, input logic [4:0] wba,
                       input logic [31:0] wbd, input bit rstv);
      kind_t       k;
      logic [4:0]  s, t;
      logic [31:0] a, b, tgt;
      bit          rs_u, rt_u, is_br, hz, tk, br;
      int          off;
      comb_t       c;
      ex_t         e;
      @(negedge clk);
      rst               = rstv;
      bus.Instruction_F = instr;
      bus.PcPlus4_F     = pc4;
      bus.ex_reg_write  = exrw;
      bus.ex_mem_read   = exmr;
      bus.ex_dst        = exdst;
      bus.wb_we         = wbwe;
      bus.wb_addr       = wba;
      bus.wb_data       = wbd;

      k = kind_of(m_instr);
      s = m_instr[25:21];
      t = m_instr[20:16];
      a = (s == 0) ? 32'd0 : (wbwe && wba == s) ? wbd : m_rf[s];
      b = (t == 0) ? 32'd0 : (wbwe && wba == t) ? wbd : m_rf[t];
      rs_u  = !(k == K_J || k == K_BAD);
      rt_u  = (k <= K_SLT) || k == K_RNOP || k == K_SW || k == K_BEQ || k == K_BNE;
      is_br = (k == K_BEQ) || (k == K_BNE);
      hz = m_v && exdst != 0 && ((rs_u && exdst == s) || (rt_u && exdst == t)) &&
           (exmr || (is_br && exrw));
      tk = (k == K_J) || (k == K_BEQ && a == b) || (k == K_BNE && a != b);
      br = m_v && !hz && tk;
      off = $signed(m_instr[15:0]);
      tgt = (k == K_J) ? {m_pc4[31:28], m_instr[25:0], 2'b00} : m_pc4 + 32'(off * 4);

      if (m_known) begin
         c.stall  = hz;
         c.branch = br;
         c.pc     = tgt;
         c.chk_pc = br || (m_instr == 0 && m_pc4 == 0);
         comb_q.push_back(c);
      end

      e = '{v: 1'b0, pc4: '0, a: '0, b: '0, imm: '0, rs: '0, rt: '0, rd: '0, ctrl: '0};
      if (rstv && !hz && m_v) begin
         e.v    = 1'b1;
         e.pc4  = m_pc4;
         e.a    = a;
         e.b    = b;
         e.imm  = 32'(off);
         e.rs   = s;
         e.rt   = t;
         e.rd   = m_instr[15:11];
         e.ctrl = ctrl_of(k);
      end
      ex_q.push_back(e);

      if (!rstv) begin
         m_known = 1;
         m_v     = 0;
         m_instr = '0;
         m_pc4   = '0;
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
      end else begin
         if (wbwe && wba != 0) m_rf[wba] = wbd;
         if (!hz) begin
            m_v     = !br;
            m_instr = br ? 32'd0 : instr;
            m_pc4   = br ? 32'd0 : pc4;
         end
      end
   endtask

   task automatic nop(input logic [31:0] pc4);
      step(32'd0, pc4, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] d);
      step(32'd0, 32'd0, 0, 0, 5'd0, 1, r, d, 1);
   endtask

   // monitor for the combinational fetch-facing outputs
   initial begin
      comb_t c;
      forever begin
         @(negedge clk);
         #2;
         if (comb_q.size() > 0) begin
            c = comb_q.pop_front();
            checks++;
            if (bus.stall_F !== c.stall) begin
               errs++;
               $display("FAIL stall_F t=%0t got=%b want=%b", $time, bus.stall_F, c.stall);
            end
            checks++;
            if (bus.branch !== c.branch) begin
               errs++;
               $display("FAIL branch t=%0t got=%b want=%b", $time, bus.branch, c.branch);
            end
            if (c.chk_pc) begin
               checks++;
               if (bus.pc_branch !== c.pc) begin
                  errs++;
                  $display("FAIL pc_branch t=%0t got=%h want=%h", $time, bus.pc_branch, c.pc);
               end
            end
         end
      end
   end

   // monitor for the registered ID/EX bundle
   initial begin
      ex_t          e;
      logic [153:0] act, exp;
      forever begin
         @(posedge clk);
         #1;
         if (ex_q.size() > 0) begin
            e   = ex_q.pop_front();
            act = {bus.valid_E, bus.PcPlus4_E, bus.rs_data_E, bus.rt_data_E, bus.imm_E,
                   bus.rs_E, bus.rt_E, bus.rd_E, bus.ctrl_E};
            exp = {e.v, e.pc4, e.a, e.b, e.imm, e.rs, e.rt, e.rd, e.ctrl};
            checks++;
            if (act !== exp) begin
               errs++;
               $display("FAIL id_ex t=%0t got=%h want=%h", $time, act, exp);
            end
         end
      end
   end

   initial begin
      // reset for two cycles
      step(32'd0, 32'd0, 0, 0, 5'd0, 0, 5'd0, 32'd0, 0);
      step(32'd0, 32'd0, 0, 0, 5'd0, 0, 5'd0, 32'd0, 0);
      // r5 reads back as zero after reset
      step(enc_r(6'h20, 5'd6, 5'd5, 5'd5), 32'h4, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      // WB bypass: r3 written while decode reads it
      step(enc_r(6'h20, 5'd1, 5'd3, 5'd3), 32'h8, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      step(32'd0, 32'hC, 0, 0, 5'd0, 1, 5'd3, 32'h1234, 1);
      // load-use on r4
      step(enc_r(6'h20, 5'd2, 5'd4, 5'd0), 32'h10, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      step(32'd0, 32'h14, 1, 1, 5'd4, 0, 5'd0, 32'd0, 1);
      nop(32'h14);
      // r1 = r2 = r4 = 7
      wb(5'd1, 32'd7);
      wb(5'd2, 32'd7);
      wb(5'd4, 32'd7);
      // beq taken, forward offset
      step(enc_i(6'h04, 5'd2, 5'd1, 16'h0003), 32'h100, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      step(enc_r(6'h20, 5'd7, 5'd7, 5'd7), 32'h104, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      nop(32'h10C);
      // bne taken, negative offset (r1=7, r3=0x1234)
      step(enc_i(6'h05, 5'd3, 5'd1, 16'hFFFE), 32'h100, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      nop(32'h104);
      nop(32'hFC);
      // j
      step(enc_j(26'h10), 32'h40000004, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      nop(32'h40000008);
      nop(32'h40000044);
      // beq on r4 behind a lw to r4: stall first, then redirect
      step(enc_i(6'h04, 5'd1, 5'd4, 16'h0005), 32'h200, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      step(32'd0, 32'h204, 1, 1, 5'd4, 0, 5'd0, 32'd0, 1);
      nop(32'h204);
      nop(32'h218);
      // ALU-to-branch dependency
      step(enc_i(6'h05, 5'd2, 5'd1, 16'h0001), 32'h300, 0, 0, 5'd0, 0, 5'd0, 32'd0, 1);
      step(32'd0, 32'h304, 1, 0, 5'd2, 0, 5'd0, 32'd0, 1);
      nop(32'h304);
      // randomized traffic with a reset dropped in mid-stream
      for (int i = 0; i < 600; i++) begin
         step(rand_instr(), $urandom & 32'hFFFF_FFFC,
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)),
              ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
              (i != 300));
      end
      nop(32'd0);
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (comb_q.size() != 0 || ex_q.size() != 0) begin
         errs++;
         $display("FAIL drain comb_left=%0d ex_left=%0d want=0", comb_q.size(), ex_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
